// File: rtl/cube_ctrl_pkg.sv
// cube_ctrl_pkg: shared state/transaction types and default widths for the LED frame sequencer.
package cube_ctrl_pkg;
    localparam int DEF_SHIFT_WIDTH  = 16;
    localparam int DEF_PWM_BITS     = 8;
    localparam int DEF_NUM_LAYERS   = 16;
    localparam int DEF_BLANK_CYCLES = 4;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, BLANK} state_t;
    typedef enum logic {TXN_PWM, TXN_BRIGHT} txn_t;
endpackage

// File: rtl/led_frame_sequencer_serial_bit_timer.sv
// serial_bit_timer: two-phase bit clock for one shift transaction; raises last_bit on the final phase.
module serial_bit_timer #(
    parameter int SHIFT_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic shift,
    output logic serial_clk,
    output logic last_bit
);
    localparam int CW = $clog2(2 * SHIFT_WIDTH);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk)
        cnt <= (reset || !run) ? '0 : cnt + 1'b1;

    assign serial_clk = run && !cnt[0];
    assign shift      = run && cnt[0];
    assign last_bit   = run && (cnt == CW'(2 * SHIFT_WIDTH - 1));
endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: drives PWM time, PISO strobes, sink clock/latch and layer stepping.
// Optional LAYER_BLANK_EN inserts a BLANK_CYCLES output-disable gap at each layer change.
module led_frame_sequencer
    import cube_ctrl_pkg::*;
#(
    parameter int SHIFT_WIDTH  = DEF_SHIFT_WIDTH,
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          brightness_req,
    output logic [PWM_BITS-1:0]           pwm_time,
    output logic                          load_led_vals,
    output logic                          load_brightness,
    output logic                          shift,
    output logic                          serial_clk,
    output logic                          latch,
    output logic                          brightness_latch,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_sel,
    output logic                          layer_oe,
    output logic                          frame_done,
    output logic                          busy
);
    localparam int LW = $clog2(NUM_LAYERS);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
`ifdef LAYER_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    state_t        state, state_next;
    txn_t          txn;
    logic          pending, svc_ok, last_bit, wrap, layer_wrap, do_bright;
    logic [BW-1:0] blank_cnt;

    serial_bit_timer #(.SHIFT_WIDTH(SHIFT_WIDTH)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (state == SHIFT),
        .shift      (shift),
        .serial_clk (serial_clk),
        .last_bit   (last_bit)
    );

    // Brightness reloads only at period boundaries so a PWM period is never split.
    assign do_bright  = pending && svc_ok;
    assign wrap       = (txn == TXN_PWM) && (pwm_time == '1);
    assign layer_wrap = wrap && (layer_sel == LW'(NUM_LAYERS - 1));
    assign busy       = state != IDLE;
    assign layer_oe   = (state != IDLE) && (state != BLANK);

    always_comb begin
        state_next       = state;
        load_led_vals    = 1'b0;
        load_brightness  = 1'b0;
        latch            = 1'b0;
        brightness_latch = 1'b0;
        frame_done       = 1'b0;
        case (state)
            IDLE:  state_next = enable ? LOAD : IDLE;
            LOAD: begin
                state_next      = SHIFT;
                load_brightness = do_bright;
                load_led_vals   = !do_bright;
            end
            SHIFT: state_next = last_bit ? LATCH : SHIFT;
            LATCH: begin
                latch            = txn == TXN_PWM;
                brightness_latch = txn == TXN_BRIGHT;
                frame_done       = layer_wrap;
                state_next       = (BLANK_EN && wrap) ? BLANK : enable ? LOAD : IDLE;
            end
            BLANK: state_next = (blank_cnt == BW'(BLANK_CYCLES - 1)) ? (enable ? LOAD : IDLE) : BLANK;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            txn       <= TXN_PWM;
            pending   <= 1'b1;
            svc_ok    <= 1'b0;
            pwm_time  <= '0;
            layer_sel <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_next;
            pending   <= ((state == LATCH && txn == TXN_BRIGHT) ? 1'b0 : pending) | brightness_req;
            svc_ok    <= ((state == IDLE && enable) || (state == LATCH && wrap)) ? 1'b1 :
                         (state == LOAD) ? 1'b0 : svc_ok;
            blank_cnt <= (state == BLANK) ? blank_cnt + 1'b1 : '0;
            if (state == LOAD)
                txn <= do_bright ? TXN_BRIGHT : TXN_PWM;
            if (state == LATCH && txn == TXN_PWM) begin
                pwm_time <= pwm_time + 1'b1;
                if (wrap)
                    layer_sel <= layer_wrap ? '0 : layer_sel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer: scoreboard bench; expected latch events queued at stimulus, checked at latch.
module tb_led_frame_sequencer;
    localparam int SW = 16;
    localparam int PB = 3;
    localparam int NL = 4;
    localparam int BC = 4;

    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0, brightness_req = 1'b0;
    logic [PB-1:0] pwm_time;
    logic [1:0]    layer_sel;
    logic          load_led_vals, load_brightness, shift, serial_clk, latch, brightness_latch;
    logic          layer_oe, frame_done, busy;

    typedef struct packed {
        logic          br;
        logic [PB-1:0] pt;
        logic [1:0]    ls;
        logic          fd;
    } exp_t;

    exp_t          q[$];
    exp_t          e_m;
    int            checks = 0, errors = 0, cyc = 0, load_cyc = 0, shifts = 0, rises = 0;
    int            latch_cnt = 0, lo_run = 0;
    logic          sclk_q = 1'b0, m_pend, m_svc;
    logic [PB-1:0] m_pt;
    logic [1:0]    m_ls;

    led_frame_sequencer #(
        .SHIFT_WIDTH(SW), .PWM_BITS(PB), .NUM_LAYERS(NL), .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .brightness_req(brightness_req),
        .pwm_time(pwm_time), .load_led_vals(load_led_vals), .load_brightness(load_brightness),
        .shift(shift), .serial_clk(serial_clk), .latch(latch), .brightness_latch(brightness_latch),
        .layer_sel(layer_sel), .layer_oe(layer_oe), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference model of one step: a reload happens only when pending at a period boundary.
    task automatic push_step();
        exp_t e;
        e.br  = m_pend && m_svc;
        m_svc = 1'b0;
        e.pt  = m_pt;
        e.ls  = m_ls;
        e.fd  = 1'b0;
        if (e.br)
            m_pend = 1'b0;
        else begin
            e.fd = (m_pt == '1) && (m_ls == 2'(NL - 1));
            if (m_pt == '1) begin
                m_ls  = m_ls + 1'b1;
                m_svc = 1'b1;
            end
            m_pt = m_pt + 1'b1;
        end
        q.push_back(e);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) push_step();
    endtask

    task automatic wait_latches(input int target);
        int budget = (target - latch_cnt) * 40 + 100;
        while (latch_cnt < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("latch_timeout", latch_cnt >= target, 1);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (load_led_vals || load_brightness) begin
                if (q.size() > 0) chk("load_kind", load_brightness, q[0].br);
                load_cyc = cyc;
                shifts   = 0;
                rises    = 0;
            end
            chk("shift_vs_load", shift && (load_led_vals || load_brightness), 0);
            if (shift) shifts++;
            if (serial_clk && !sclk_q) rises++;
            sclk_q = serial_clk;
`ifdef LAYER_BLANK_EN
            if (busy && !layer_oe)
                lo_run++;
            else begin
                if (lo_run > 0) chk("blank_len", lo_run, BC);
                lo_run = 0;
            end
`else
            chk("layer_oe", layer_oe, busy);
`endif
            if (latch || brightness_latch) begin
                latch_cnt++;
                if (q.size() == 0)
                    chk("unexpected_latch", q.size(), 1);
                else begin
                    e_m = q.pop_front();
                    chk("latch_kind", brightness_latch, e_m.br);
                    chk("latch", latch, !e_m.br);
                    chk("pwm_time", pwm_time, e_m.pt);
                    chk("layer_sel", layer_sel, e_m.ls);
                    chk("frame_done", frame_done, e_m.fd);
                    chk("shift_count", shifts, SW);
                    chk("sclk_rises", rises, SW);
                    chk("step_len", cyc - load_cyc, 2 * SW + 1);
                end
            end else
                chk("frame_done_idle", frame_done, 0);
        end
    end

    initial begin
        m_pend = 1'b1;
        m_svc  = 1'b0;
        m_pt   = '0;
        m_ls   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pwm_time", pwm_time, 0);
        chk("rst_layer_sel", layer_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_layer_oe", layer_oe, 0);
        chk("rst_strobes", {load_led_vals, load_brightness, shift, serial_clk, latch, brightness_latch, frame_done}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_hold", busy, 0);
        m_svc = 1'b1;
        push_n(11);
        enable = 1'b1;
        @(negedge clk);
        chk("c1_load_brightness", load_brightness, 1);
        chk("c1_load_led_vals", load_led_vals, 0);
        wait_latches(11);
        push_n(30);
        wait_latches(41);
        push_n(4);
        wait_latches(45);
        push_n(1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        brightness_req = 1'b1;
        @(negedge clk);
        brightness_req = 1'b0;
        m_pend = 1'b1;
        push_n(8);
        repeat (40) @(negedge clk);
        brightness_req = 1'b1;
        @(negedge clk);
        brightness_req = 1'b0;
        wait_latches(54);
        push_n(1);
        repeat (11) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        wait_latches(55);
        repeat (3) @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_layer_oe", layer_oe, 0);
        chk("stop_pwm_time", pwm_time, m_pt);
        chk("stop_layer_sel", layer_sel, m_ls);
        repeat (20) @(negedge clk);
        chk("hold_pwm_time", pwm_time, m_pt);
        m_svc = 1'b1;
        push_n(5);
        enable = 1'b1;
        wait_latches(60);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_pwm_time", pwm_time, 0);
        chk("abort_layer_sel", layer_sel, 0);
        chk("abort_strobes", {load_led_vals, load_brightness, shift, serial_clk, latch, brightness_latch}, 0);
        repeat (40) @(negedge clk);
        chk("abort_no_latch", latch_cnt, 60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
